fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-bit, 1024-deep TOP_FIFO among NREQ producers. Grants are issued in bursts of up to BURST words. The write strobe is throttled by the FIFO's FULL flag, so no producer can overflow the FIFO. It sits directly in front of TOP_FIFO's DIN/WE_N pins. The read side (OE_N/DOUT/EMPTY) is untouched.

## Interface
- WIDTH, 8: data word width; matches FIFO DIN.
- NREQ, 2: number of producers; legal range 2..4.
- BURST, 4: maximum words accepted per grant; legal range 1..16.

- CLK  in  1: single clock; all state updates on the rising edge.
- RST  in  1: reset, synchronous, active-high.
- REQ  in  NREQ: per-producer request; held high while that producer has a word on its DATA slice.
- DATA  in  NREQ*WIDTH: producer words; slice i is DATA[i*WIDTH +: WIDTH].
- GNT  out  NREQ: registered one-hot grant; all-zero when idle.
- ACK  out  NREQ: combinational one-hot; high means the presented word is written at this edge.
- BUSY  out  1: registered; high in state BURST.
- FIFO_FULL  in  1: FIFO FULL flag; registered inside the FIFO.
- FIFO_DIN  out  WIDTH: DATA slice of the granted producer; all-zero when no grant.
- FIFO_WE_N  out  1: active-low write strobe to the FIFO.

## Operation
- The FSM has two states, IDLE and BURST. Registered state: state, grant index g, round-robin pointer last, burst counter cnt (width clog2(BURST+1)).
- The write condition is wr = (state==BURST) & REQ[g] & ~FIFO_FULL & ~RST.
  - FIFO_WE_N = ~wr.
  - ACK[g] = wr.
  - All other ACK bits are 0.
- IDLE:
  - If any REQ bit is set, pick the first requester searching from last+1 modulo NREQ.
  - Load g with it, set GNT one-hot, clear cnt, go to BURST.
  - Otherwise stay in IDLE.
- BURST, each cycle:
  - If wr is high, cnt increments.
  - If FIFO_FULL is high, nothing changes: grant and cnt hold, no ACK. There is no stall timeout.
  - The burst ends at this edge when (wr & cnt==BURST-1) or REQ[g]==0.
- At burst end:
  - last is set to g.
  - Re-arbitrate immediately over the current REQ vector, searching from g+1. A producer whose REQ is still high is a candidate, including g itself if it is the only one requesting.
  - If there is a winner, stay in BURST with the new g and cnt=0. Otherwise go to IDLE and set GNT=0.
- Producers must not change their DATA slice while their REQ is high and ACK is low.
- Reset values: state=IDLE, GNT=0, BUSY=0, cnt=0, last=NREQ-1 (requester 0 has first priority), ACK=0, FIFO_WE_N=1, FIFO_DIN=0.
- Reset mid-burst: in the cycle RST is high, wr is forced low, so no write is issued. The next cycle is IDLE.

## Timing
- Grant latency: REQ rises in cycle 0 while IDLE → GNT and BUSY in cycle 1 → first ACK/WE_N low in cycle 1 if not FULL.
- Back-to-back bursts run with no bubble. With BURST=4 and both producers always requesting, ACK alternates in groups of 4 with no idle cycle.
- A burst that ends because REQ[g] dropped costs one cycle with no write.
- FULL is acted on in the same cycle it is observed. The FIFO updates FULL at the edge of the last write, so a write is never issued while FULL is high.
- Throughput is at most one word per cycle.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - default constants WIDTH=8, NREQ=2, BURST=4;
  - the FIFO depth constant 1024.
- Sub-module fifo_rr_pick is a combinational round-robin picker.
  - Inputs: REQ vector and pointer.
  - Outputs: valid and winner index.
  - It is instantiated once and serves both the IDLE and burst-end arbitration.
- Everything else lives in fifo_wr_arbiter: FSM, counter, output muxing.

## Test plan
- Reset: hold RST for 2 cycles with REQ=2'b11 → GNT=0, FIFO_WE_N=1, ACK=0. In the first cycle after reset, GNT=2'b01.
- Round-robin burst: both producers request continuously, producer 0 sends 0x00.., producer 1 sends 0x80.. → FIFO receives 00,01,02,03,80,81,82,83,04,… and WE_N is low every cycle.
- Early release: producer 1 drops REQ after 2 words while producer 0 requests → one cycle with no write, then GNT=2'b01 and producer 0 gets a full 4-word burst.
- Full stall: drive 1030 words into the real TOP_FIFO from producer 0 with no reads → exactly 1024 ACKs, then FIFO_WE_N stays 1 while FULL=1 and GNT holds 2'b01. After one read (OE_N low), exactly one more ACK.
- Reset mid-burst: assert RST in the 2nd word of a burst → no ACK or write in that cycle, then state is IDLE and the grant restarts from producer 0.
- Single requester re-grant: only producer 1 requests 10 words → bursts of 4, 4, 2 with no idle cycle between them. GNT stays 2'b10 throughout, then drops to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the TOP_FIFO write-port arbiter.
package fifo_arb_pkg;

    // Default parameterisation: 8-bit words, two producers, 4-word bursts.
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NREQ   = 2;
    localparam int DEF_BURST  = 4;

    // Depth of the TOP_FIFO this arbiter feeds.
    localparam int FIFO_DEPTH = 1024;

    // Arbiter FSM: waiting for a requester, or streaming a granted burst.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-facing signal bundle of the write-port arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
);
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] DATA;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       ACK;
    logic                  BUSY;
    logic                  FIFO_FULL;
    logic [WIDTH-1:0]      FIFO_DIN;
    logic                  FIFO_WE_N;

    // Producers and the FIFO flag drive the arbiter.
    modport master (
        output REQ, DATA, FIFO_FULL,
        input  GNT, ACK, BUSY, FIFO_DIN, FIFO_WE_N
    );

    // The arbiter itself.
    modport slave (
        input  REQ, DATA, FIFO_FULL,
        output GNT, ACK, BUSY, FIFO_DIN, FIFO_WE_N
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching from
// ptr+1 upward, wrapping modulo NREQ. ptr itself is the lowest priority.
module fifo_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Scan offsets 1..NREQ from the pointer; the first hit wins.
    always_comb begin
        int unsigned c;
        logic [IW-1:0] c_idx;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            c     = (32'(ptr) + i) % NREQ;
            c_idx = IW'(c);
            if (!valid && req[c_idx]) begin
                valid = 1'b1;
                idx   = c_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter sharing TOP_FIFO's single write port
// among NREQ producers. Writes are throttled by the FIFO FULL flag.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int BURST = DEF_BURST
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    arb_state_e      state, state_n;
    logic [IW-1:0]   g, g_n;
    logic [IW-1:0]   last, last_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] gnt, gnt_n;

    logic            wr;
    logic            burst_end;
    logic [IW-1:0]   pick_ptr;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    // One picker serves both arbitration points: from IDLE the search starts
    // after last; at burst end it starts after g, which becomes the new last.
    assign pick_ptr = (state == S_BURST) ? g : last;

    fifo_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (bus.REQ),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign wr        = (state == S_BURST) && bus.REQ[g] && !bus.FIFO_FULL && !RST;
    assign burst_end = (state == S_BURST) &&
                       ((wr && (cnt == CW'(BURST - 1))) || !bus.REQ[g]);

    // Next-state logic: grant loading, burst counting and re-arbitration.
    always_comb begin
        state_n = state;
        g_n     = g;
        last_n  = last;
        cnt_n   = cnt;
        gnt_n   = gnt;
        unique case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_n          = S_BURST;
                    g_n              = pick_idx;
                    cnt_n            = '0;
                    gnt_n            = '0;
                    gnt_n[pick_idx]  = 1'b1;
                end
            end
            S_BURST: begin
                if (wr) begin
                    cnt_n = cnt + CW'(1);
                end
                if (burst_end) begin
                    last_n = g;
                    cnt_n  = '0;
                    if (pick_valid) begin
                        g_n             = pick_idx;
                        gnt_n           = '0;
                        gnt_n[pick_idx] = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State registers; last resets to NREQ-1 so producer 0 is favoured first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            g     <= '0;
            last  <= IW'(NREQ - 1);
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            last  <= last_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
        end
    end

    // Output muxing: acknowledge only the granted producer, forward its word.
    always_comb begin
        bus.ACK      = '0;
        bus.ACK[g]   = wr;
        bus.FIFO_DIN = '0;
        if (state == S_BURST) begin
            bus.FIFO_DIN = bus.DATA[int'(g)*WIDTH +: WIDTH];
        end
    end

    assign bus.GNT       = gnt;
    assign bus.BUSY      = (state == S_BURST);
    assign bus.FIFO_WE_N = !wr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural 1024-deep FIFO
// occupancy model providing the registered FULL flag.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int W = 8;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus();

    fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] p0, p1;      // next word each producer presents
    int         fifo_cnt;    // FIFO occupancy model
    logic       oe;          // one-word read from the FIFO at the next edge
    int         acks0;

    logic [7:0] rr_exp [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
                                8'h04, 8'h05, 8'h06, 8'h07, 8'h84, 8'h85, 8'h86, 8'h87};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: apply FIFO and producer effects of the edge, then
    // drive the new inputs away from the edge.
    task automatic cycle();
        logic [N-1:0] a;
        logic         we_n;
        a    = bus.ACK;
        we_n = bus.FIFO_WE_N;
        check("no_write_while_full", {31'b0, bus.FIFO_FULL & ~we_n}, 32'd0);
        @(posedge clk);
        #1;
        if (!we_n) fifo_cnt++;
        if (oe && fifo_cnt > 0) fifo_cnt--;
        bus.FIFO_FULL = (fifo_cnt >= FIFO_DEPTH);
        if (a[0]) begin p0++; acks0++; end
        if (a[1]) p1++;
        bus.DATA = {p1, p0};
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.REQ       = 2'b11;
        p0            = 8'h00;
        p1            = 8'h80;
        bus.DATA      = {p1, p0};
        bus.FIFO_FULL = 1'b0;
        oe            = 1'b0;
        fifo_cnt      = 0;
        acks0         = 0;
        #1;

        // Reset held two cycles with both producers requesting
        cycle();
        cycle();
        check("rst_gnt",  bus.GNT,       32'h0);
        check("rst_we_n", bus.FIFO_WE_N, 32'h1);
        check("rst_ack",  bus.ACK,       32'h0);
        check("rst_busy", bus.BUSY,      32'h0);
        check("rst_din",  bus.FIFO_DIN,  32'h0);
        rst = 1'b0;
        #1;
        check("idle_gnt", bus.GNT, 32'h0);
        cycle();
        check("first_gnt",  bus.GNT,  32'h1);
        check("first_busy", bus.BUSY, 32'h1);

        // Round robin: alternating 4-word bursts with no bubble
        for (int k = 0; k < 16; k++) begin
            check("rr_we_n", bus.FIFO_WE_N, 32'h0);
            check("rr_din",  bus.FIFO_DIN,  rr_exp[k]);
            check("rr_gnt",  bus.GNT,       ((k / 4) % 2 == 0) ? 32'h1 : 32'h2);
            cycle();
        end

        // Early release: producer 1 leaves after two words
        for (int k = 0; k < 4; k++) begin
            check("er_p0_din", bus.FIFO_DIN, 32'h08 + k);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            check("er_p1_din", bus.FIFO_DIN, 32'h88 + k);
            check("er_p1_gnt", bus.GNT,      32'h2);
            cycle();
        end
        bus.REQ = 2'b01;
        #1;
        check("er_gap_we_n", bus.FIFO_WE_N, 32'h1);
        check("er_gap_ack",  bus.ACK,       32'h0);
        cycle();
        check("er_regnt", bus.GNT, 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("er_full_we_n", bus.FIFO_WE_N, 32'h0);
            check("er_full_ack",  bus.ACK,       32'h1);
            check("er_full_din",  bus.FIFO_DIN,  32'h0C + k);
            cycle();
        end

        // Reset during the second word of a burst
        check("mr_w1_din", bus.FIFO_DIN, 32'h10);
        cycle();
        bus.REQ = 2'b11;
        rst     = 1'b1;
        #1;
        check("mr_we_n", bus.FIFO_WE_N, 32'h1);
        check("mr_ack",  bus.ACK,       32'h0);
        cycle();
        rst = 1'b0;
        #1;
        check("mr_idle_gnt",  bus.GNT,      32'h0);
        check("mr_idle_busy", bus.BUSY,     32'h0);
        check("mr_idle_din",  bus.FIFO_DIN, 32'h0);
        cycle();
        check("mr_regnt",     bus.GNT,      32'h1);
        check("mr_regnt_din", bus.FIFO_DIN, 32'h11);

        // Single requester: producer 1 sends 10 words, re-granted to itself
        bus.REQ = 2'b00;
        #1;
        cycle();
        check("sr_idle_gnt", bus.GNT, 32'h0);
        bus.REQ = 2'b10;
        #1;
        cycle();
        check("sr_gnt", bus.GNT, 32'h2);
        for (int k = 0; k < 10; k++) begin
            check("sr_we_n", bus.FIFO_WE_N, 32'h0);
            check("sr_gnt",  bus.GNT,       32'h2);
            check("sr_din",  bus.FIFO_DIN,  32'h8A + k);
            cycle();
        end
        bus.REQ = 2'b00;
        #1;
        check("sr_end_we_n", bus.FIFO_WE_N, 32'h1);
        cycle();
        check("sr_end_gnt",  bus.GNT,  32'h0);
        check("sr_end_busy", bus.BUSY, 32'h0);

        // Full stall: empty FIFO, producer 0 streams until FULL
        fifo_cnt      = 0;
        bus.FIFO_FULL = 1'b0;
        acks0         = 0;
        bus.REQ       = 2'b01;
        #1;
        for (int k = 0; k < 1100; k++) cycle();
        check("fs_acks",  acks0,         32'd1024);
        check("fs_full",  bus.FIFO_FULL, 32'h1);
        check("fs_we_n",  bus.FIFO_WE_N, 32'h1);
        check("fs_ack",   bus.ACK,       32'h0);
        check("fs_gnt",   bus.GNT,       32'h1);
        oe = 1'b1;
        cycle();
        oe = 1'b0;
        check("fs_rd_we_n", bus.FIFO_WE_N, 32'h0);
        check("fs_rd_ack",  bus.ACK,       32'h1);
        for (int k = 0; k < 5; k++) cycle();
        check("fs_rd_acks", acks0,         32'd1025);
        check("fs_rd_full", bus.FIFO_FULL, 32'h1);
        check("fs_rd_hold", bus.FIFO_WE_N, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
